// File: rtl/gcm_ghash_tag_stage_if.sv
// Beat/result bundle between the last AES-GCM pipeline stage and the GHASH/tag stage.
// master = upstream producer, slave = gcm_ghash_tag_stage.
interface gcm_ghash_tag_stage_if;
  logic         i_valid;
  logic         o_ready;
  logic [0:1]   i_phase;
  logic         i_new_instance;
  logic [0:127] i_h;
  logic [0:127] i_encrypted_j0;
  logic [0:127] i_encrypted_cb;
  logic [0:127] i_plain_text;
  logic [0:127] i_aad;
  logic [0:127] i_instance_size;
  logic [0:4]   i_block_bytes;
  logic [0:127] o_cipher_text;
  logic         o_cipher_valid;
  logic [0:127] o_tag;
  logic         o_tag_valid;

  modport master (
    output i_valid, i_phase, i_new_instance, i_h, i_encrypted_j0, i_encrypted_cb,
           i_plain_text, i_aad, i_instance_size, i_block_bytes,
    input  o_ready, o_cipher_text, o_cipher_valid, o_tag, o_tag_valid
  );

  modport slave (
    input  i_valid, i_phase, i_new_instance, i_h, i_encrypted_j0, i_encrypted_cb,
           i_plain_text, i_aad, i_instance_size, i_block_bytes,
    output o_ready, o_cipher_text, o_cipher_valid, o_tag, o_tag_valid
  );
endinterface

// File: rtl/gcm_ghash_tag_stage.sv
// AES-GCM tail stage: ciphertext = P xor E(CB), GHASH over AAD/C/length with a
// digit-serial GF(2^128) multiplier (DIGIT_W bits of H per cycle), tag = GHASH xor E(J0).
module gcm_ghash_tag_stage #(
  parameter int DIGIT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcm_ghash_tag_stage_if.slave bus
);
  localparam int N     = 128 / DIGIT_W;
  localparam int CNT_W = $clog2(N);

  typedef enum logic {IDLE, MULT} state_t;

  state_t             state_reg, state_next;
  logic               ready_reg, ready_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [0:1]         phase_reg;
  logic [0:127]       x_reg, z_reg, v_reg, h_reg, ej0_reg;
  logic [0:127]       cipher_reg, tag_reg;
  logic               cipher_valid_reg, tag_valid_reg;

  logic               start, last;
  logic [4:0]         blk_bytes;
  logic [0:127]       keep_mask, cipher_c, x_base, operand;
  logic [0:DIGIT_W-1] h_digit;
  logic [0:127]       z_step, v_step;
  logic               v_lsb;

  // Phase 11 is consumed in IDLE without touching any state.
  assign start = bus.i_valid && ready_reg && (bus.i_phase != 2'b11);
  assign last  = (state_reg == MULT) && (cnt_reg == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = MULT;
      MULT:    if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE);
  end

  // Byte b of the payload survives only when b < valid byte count (0 encodes 16).
  assign blk_bytes = ((bus.i_block_bytes == 5'd0) || (bus.i_block_bytes > 5'd16)) ?
                     5'd16 : bus.i_block_bytes;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mask
      assign keep_mask[gi*8 +: 8] = (blk_bytes > 5'(gi)) ? 8'hff : 8'h00;
    end
  endgenerate

  assign cipher_c = (bus.i_plain_text ^ bus.i_encrypted_cb) & keep_mask;
  assign x_base   = bus.i_new_instance ? 128'd0 : x_reg;

  always_comb begin
    operand = bus.i_instance_size;
    case (bus.i_phase)
      2'b00:   operand = bus.i_aad;
      2'b01:   operand = cipher_c;
      default: operand = bus.i_instance_size;
    endcase
  end

  assign h_digit = h_reg[int'(cnt_reg) * DIGIT_W +: DIGIT_W];

  // DIGIT_W unrolled steps of the bit-serial GCM multiply; V shifts toward index 127.
  always_comb begin
    z_step = z_reg;
    v_step = v_reg;
    v_lsb  = 1'b0;
    for (int j = 0; j < DIGIT_W; j++) begin
      if (h_digit[j]) z_step = z_step ^ v_step;
      v_lsb  = v_step[127];
      v_step = {1'b0, v_step[0:126]};
      if (v_lsb) v_step[0:7] = v_step[0:7] ^ 8'he1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      phase_reg        <= 2'b00;
      x_reg            <= '0;
      z_reg            <= '0;
      v_reg            <= '0;
      h_reg            <= '0;
      ej0_reg          <= '0;
      cipher_reg       <= '0;
      tag_reg          <= '0;
      cipher_valid_reg <= 1'b0;
      tag_valid_reg    <= 1'b0;
    end else begin
      cipher_valid_reg <= 1'b0;
      tag_valid_reg    <= 1'b0;
      if (start) begin
        if (bus.i_new_instance) begin
          h_reg   <= bus.i_h;
          ej0_reg <= bus.i_encrypted_j0;
        end
        v_reg     <= x_base ^ operand;
        z_reg     <= '0;
        cnt_reg   <= '0;
        phase_reg <= bus.i_phase;
        if (bus.i_phase == 2'b01) begin
          cipher_reg       <= cipher_c;
          cipher_valid_reg <= 1'b1;
        end
      end else if (state_reg == MULT) begin
        if (last) begin
          x_reg <= z_step;
          if (phase_reg == 2'b10) begin
            tag_reg       <= z_step ^ ej0_reg;
            tag_valid_reg <= 1'b1;
          end
        end else begin
          z_reg   <= z_step;
          v_reg   <= v_step;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign bus.o_ready        = ready_reg;
  assign bus.o_cipher_text  = cipher_reg;
  assign bus.o_cipher_valid = cipher_valid_reg;
  assign bus.o_tag          = tag_reg;
  assign bus.o_tag_valid    = tag_valid_reg;
endmodule

// File: tb/tb_gcm_ghash_tag_stage.sv
// Scoreboard bench for gcm_ghash_tag_stage: GCM known answers plus randomized
// messages checked against a whole-block GHASH reference model.
module tb_gcm_ghash_tag_stage;
  localparam int DW = 8;
  localparam int N  = 128 / DW;

  localparam logic [0:127] KH   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] KEJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] KCB  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] KTAG = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gcm_ghash_tag_stage_if bus ();
  gcm_ghash_tag_stage #(.DIGIT_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  logic [0:127] exp_ct_q[$];
  logic [0:127] exp_tag_q[$];
  int           ct_acc_q[$];
  int           tag_acc_q[$];

  logic [0:127] m_x, m_h, m_ej0;

  task automatic check128(input string name, input logic [0:127] act, input logic [0:127] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Textbook GCM multiply: Z = X * Y, walking X from index 0.
  function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z = '0;
    logic [0:127] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z ^= v;
      if (v[127]) v = (v >> 1) ^ {8'he1, 120'd0};
      else        v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [0:127] mask_bytes(input logic [0:127] d, input int nb);
    logic [0:127] r = d;
    int           k = (nb == 0 || nb > 16) ? 16 : nb;
    for (int b = k; b < 16; b++) r[b*8 +: 8] = 8'h00;
    return r;
  endfunction

  always @(negedge clk) begin
    logic [0:127] e;
    int           a;
    if (rst_n) begin
      if (bus.o_cipher_valid) begin
        if (exp_ct_q.size() == 0) check_int("unexpected cipher_valid", 1, 0);
        else begin
          e = exp_ct_q.pop_front();
          a = ct_acc_q.pop_front();
          $display("[TB] cipher %h (expect %h)", bus.o_cipher_text, e);
          check128("cipher", bus.o_cipher_text, e);
          check_int("cipher latency", cyc - a + 1, 1);
        end
      end
      if (bus.o_tag_valid) begin
        if (exp_tag_q.size() == 0) check_int("unexpected tag_valid", 1, 0);
        else begin
          e = exp_tag_q.pop_front();
          a = tag_acc_q.pop_front();
          $display("[TB] tag %h (expect %h)", bus.o_tag, e);
          check128("tag", bus.o_tag, e);
          check_int("tag latency", cyc - a + 1, N + 1);
        end
      end
    end
  end

  // While the stage is busy the bus carries garbage; the real beat appears only
  // in the cycle where o_ready is high, so anything sampled early is wrong.
  task automatic send(input logic [0:1] ph, input logic ni, input logic [0:127] h,
                      input logic [0:127] ej0, input logic [0:127] cb, input logic [0:127] pt,
                      input logic [0:127] aad, input logic [0:127] sz, input int bb,
                      input bit expect_it, input bit use_kat, input logic [0:127] kat,
                      output int acc);
    int           waited = 0;
    bit           got    = 0;
    logic [0:127] xb, v, c;
    acc = -1;
    while (!got) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      if (bus.o_ready) begin
        bus.i_phase = ph;  bus.i_new_instance = ni;  bus.i_h = h;
        bus.i_encrypted_j0 = ej0;  bus.i_encrypted_cb = cb;  bus.i_plain_text = pt;
        bus.i_aad = aad;  bus.i_instance_size = sz;  bus.i_block_bytes = 5'(bb);
        got = 1;
      end else begin
        bus.i_phase = 2'($urandom);  bus.i_new_instance = 1'($urandom);  bus.i_h = rnd128();
        bus.i_encrypted_j0 = rnd128();  bus.i_encrypted_cb = rnd128();
        bus.i_plain_text = rnd128();  bus.i_aad = rnd128();  bus.i_instance_size = rnd128();
        bus.i_block_bytes = 5'($urandom);
        waited++;
        if (waited > 1000) begin
          n_tests++;  n_fail++;
          $display("FAIL ready timeout: got o_ready=0 for %0d cycles want 1", waited);
          bus.i_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (expect_it && ph != 2'b11) begin
      if (ni) begin m_h = h; m_ej0 = ej0; xb = '0; end
      else xb = m_x;
      v = xb ^ sz;
      if (ph == 2'b00) v = xb ^ aad;
      if (ph == 2'b01) begin
        c = mask_bytes(pt ^ cb, bb);
        v = xb ^ c;
        exp_ct_q.push_back(use_kat ? kat : c);
        ct_acc_q.push_back(acc);
      end
      m_x = gf_mul(m_h, v);
      if (ph == 2'b10) begin
        exp_tag_q.push_back(use_kat ? kat : (m_x ^ m_ej0));
        tag_acc_q.push_back(acc);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_int({tag, " o_ready"}, int'(bus.o_ready), 0);
    check_int({tag, " o_cipher_valid"}, int'(bus.o_cipher_valid), 0);
    check_int({tag, " o_tag_valid"}, int'(bus.o_tag_valid), 0);
    check128({tag, " o_cipher_text"}, bus.o_cipher_text, '0);
    check128({tag, " o_tag"}, bus.o_tag, '0);
  endtask

  initial begin
    int acc, prev;
    int n_aad, n_pay, bb;
    logic [0:127] h, ej0;

    bus.i_valid = 0;  bus.i_phase = 0;  bus.i_new_instance = 0;  bus.i_h = '0;
    bus.i_encrypted_j0 = '0;  bus.i_encrypted_cb = '0;  bus.i_plain_text = '0;
    bus.i_aad = '0;  bus.i_instance_size = '0;  bus.i_block_bytes = '0;
    m_x = '0;  m_h = '0;  m_ej0 = '0;
    rst_n = 1'b0;
    #23;
    check_outputs_zero("reset");
    #4 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_int("ready after reset", int'(bus.o_ready), 1);

    // Empty message: tag is E(J0).
    send(2'b10, 1, KH, KEJ0, '0, '0, '0, '0, 16, 1, 1, KEJ0, acc);
    idle(N + 3);

    // Single zero block.
    send(2'b01, 1, KH, KEJ0, KCB, '0, '0, '0, 0, 1, 1, KCB, acc);
    send(2'b10, 0, rnd128(), rnd128(), '0, '0, '0, 128'h80, 16, 1, 1, KTAG, acc);
    idle(N + 3);

    // Same block truncated to 4 bytes.
    send(2'b01, 1, KH, KEJ0, KCB, '0, '0, '0, 4, 1, 1, {32'h0388dace, 96'd0}, acc);
    send(2'b10, 0, '0, '0, '0, '0, '0, 128'h20, 16, 1, 0, '0, acc);
    idle(N + 3);

    // Back-to-back beats with i_valid held high: one accept every N+1 cycles.
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      send(2'b00, (i == 0), rnd128(), rnd128(), '0, '0, rnd128(), '0, 16, 1, 0, '0, acc);
      if (prev >= 0) check_int("accept interval", acc - prev, N + 1);
      prev = acc;
    end
    send(2'b10, 0, '0, '0, '0, '0, '0, 128'h280, 16, 1, 0, '0, acc);
    check_int("accept interval", acc - prev, N + 1);
    idle(N + 3);

    // Random messages with gaps and interleaved no-op beats.
    for (int m = 0; m < 6; m++) begin
      h     = rnd128();
      ej0   = rnd128();
      n_aad = $urandom_range(0, 2);
      n_pay = $urandom_range(1, 3);
      for (int i = 0; i < n_aad + n_pay; i++) begin
        if ($urandom_range(0, 2) == 0)
          send(2'b11, 1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 16,
               1, 0, '0, acc);
        bb = $urandom_range(0, 16);
        if (i < n_aad)
          send(2'b00, (i == 0), h, ej0, '0, '0, rnd128(), '0, 16, 1, 0, '0, acc);
        else
          send(2'b01, (i == 0), h, ej0, rnd128(), rnd128(), '0, '0, bb, 1, 0, '0, acc);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      send(2'b10, 0, '0, '0, '0, '0, '0, rnd128(), 16, 1, 0, '0, acc);
      idle($urandom_range(1, N + 2));
    end
    idle(N + 3);

    // Abort a multiply with reset, then rerun the empty message.
    send(2'b10, 1, KH, KEJ0, '0, '0, '0, '0, 16, 0, 0, '0, acc);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid-mult reset");
    repeat (3) @(negedge clk);
    check_outputs_zero("held reset");
    rst_n = 1'b1;
    idle(N + 4);
    send(2'b10, 1, KH, KEJ0, '0, '0, '0, '0, 16, 1, 1, KEJ0, acc);
    idle(N + 5);

    check_int("cipher scoreboard drained", exp_ct_q.size(), 0);
    check_int("tag scoreboard drained", exp_tag_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
